// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and flag indices for the branch/PC unit
package cpu_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_REG  = 2'b10,
        BR_IMM  = 2'b11
    } branch_e;

    typedef enum logic [2:0] {
        CC_NE = 3'b000,
        CC_EQ = 3'b001,
        CC_GT = 3'b010,
        CC_LT = 3'b011,
        CC_GE = 3'b100,
        CC_LE = 3'b101,
        CC_OV = 3'b110,
        CC_UN = 3'b111
    } cond_e;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    // Flag vector layout is {Z,V,N}
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

endpackage

// File: rtl/pc_branch_unit_if.sv
// rtl/pc_branch_unit_if.sv - decoder/ALU-facing bundle of the branch/PC unit
interface pc_branch_unit_if #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 9
);
    logic [1:0]       branch;
    logic             halt_in;
    logic             pcs;
    logic [2:0]       ccc;
    logic [IMM_W-1:0] imm;
    logic [WIDTH-1:0] br_reg;
    logic [2:0]       flag_we;
    logic [2:0]       alu_flags;
    logic             stall;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus2;
    logic [WIDTH-1:0] wb_pcs;
    logic [2:0]       flags;
    logic             taken;
    logic             halted;

    // Decoder/ALU side: drives control, observes PC state
    modport master (
        output branch, halt_in, pcs, ccc, imm, br_reg, flag_we, alu_flags, stall,
        input  pc, pc_plus2, wb_pcs, flags, taken, halted
    );

    // Branch unit side
    modport slave (
        input  branch, halt_in, pcs, ccc, imm, br_reg, flag_we, alu_flags, stall,
        output pc, pc_plus2, wb_pcs, flags, taken, halted
    );
endinterface

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - evaluates a branch condition code against {Z,V,N}
import cpu_pkg::*;

module branch_cond_eval (
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       cond_true
);
    logic z, v, n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    // Decode the condition code into a single pass/fail bit
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(ccc))
            CC_NE:   cond_true = ~z;
            CC_EQ:   cond_true = z;
            CC_GT:   cond_true = ~z & ~n;
            CC_LT:   cond_true = n;
            CC_GE:   cond_true = z | ~n;
            CC_LE:   cond_true = z | n;
            CC_OV:   cond_true = v;
            CC_UN:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end
endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - PC, flag register and run/halt FSM with next-PC resolution
import cpu_pkg::*;

module pc_branch_unit #(
    parameter int               WIDTH    = 16,
    parameter int               IMM_W    = 9,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_branch_unit_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [2:0]       flags_q, flags_d;

    logic             cond_true;
    logic             taken;
    logic [WIDTH-1:0] pc_plus2;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] b_target;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] next_pc;

    // Conditions look only at registered flags, so a same-cycle flag write cannot steer its own branch
    branch_cond_eval u_cond (
        .ccc       (bus.ccc),
        .flags     (flags_q),
        .cond_true (cond_true)
    );

    assign pc_plus2  = pc_q + WIDTH'(2);
    assign imm_sext  = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    assign b_target  = pc_plus2 + {imm_sext[WIDTH-2:0], 1'b0};
    assign br_target = {bus.br_reg[WIDTH-1:1], 1'b0};

    assign taken   = bus.branch[1] & cond_true & ~bus.halt_in & (state_q == RUN);
    assign next_pc = !taken                       ? pc_plus2 :
                     (bus.branch == BR_IMM)       ? b_target : br_target;

    assign bus.pc       = pc_q;
    assign bus.pc_plus2 = pc_plus2;
    assign bus.wb_pcs   = bus.pcs ? pc_plus2 : '0;
    assign bus.flags    = flags_q;
    assign bus.taken    = taken;
    assign bus.halted   = (state_q == HALT);

    // State, PC and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    // Next state: stall beats halt, halt beats branch, HALT is sticky until reset
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        if (state_q == RUN && !bus.stall) begin
            if (bus.halt_in) begin
                state_d = HALT;
            end else begin
                pc_d    = next_pc;
                flags_d = (bus.flag_we & bus.alu_flags) | (~bus.flag_we & flags_q);
            end
        end
    end
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - directed vector bench for pc_branch_unit
module tb_pc_branch_unit;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    pc_branch_unit_if #(.WIDTH(16), .IMM_W(9)) bus ();

    pc_branch_unit #(.WIDTH(16), .IMM_W(9), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  branch;
        logic        halt_in;
        logic        pcs;
        logic [2:0]  ccc;
        logic [8:0]  imm;
        logic [15:0] br_reg;
        logic [2:0]  flag_we;
        logic [2:0]  alu_flags;
        logic        stall;
        logic        exp_taken;
        logic [15:0] exp_wb;
        logic [15:0] exp_pc;
        logic [2:0]  exp_flags;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] br, input logic h, input logic p, input logic [2:0] c,
                         input logic [8:0] im, input logic [15:0] r, input logic [2:0] we,
                         input logic [2:0] af, input logic st);
        bus.branch    = br;
        bus.halt_in   = h;
        bus.pcs       = p;
        bus.ccc       = c;
        bus.imm       = im;
        bus.br_reg    = r;
        bus.flag_we   = we;
        bus.alu_flags = af;
        bus.stall     = st;
    endtask

    task automatic idle();
        drive(2'b00, 1'b0, 1'b0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [1:0] br, input logic h, input logic p, input logic [2:0] c,
                       input logic [8:0] im, input logic [15:0] r, input logic [2:0] we,
                       input logic [2:0] af, input logic st, input logic et,
                       input logic [15:0] ewb, input logic [15:0] epc, input logic [2:0] ef);
        vec_t v;
        v.branch = br; v.halt_in = h; v.pcs = p; v.ccc = c; v.imm = im; v.br_reg = r;
        v.flag_we = we; v.alu_flags = af; v.stall = st; v.exp_taken = et;
        v.exp_wb = ewb; v.exp_pc = epc; v.exp_flags = ef;
        vecs.push_back(v);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        rst_n = 1'b0;

        //   br     h     pcs   ccc     imm     br_reg    we      alu     st    taken wb        pc_after  flags
        add(2'b00, 1'b0, 1'b0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0002, 3'b000);
        add(2'b00, 1'b0, 1'b0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0004, 3'b000);
        add(2'b00, 1'b0, 1'b0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0006, 3'b000);
        add(2'b00, 1'b0, 1'b0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0008, 3'b000);
        add(2'b10, 1'b0, 1'b0, 3'b111, 9'h000, 16'h0011, 3'b100, 3'b100, 1'b0, 1'b1, 16'h0000, 16'h0010, 3'b100);
        add(2'b11, 1'b0, 1'b0, 3'b001, 9'h1FE, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b1, 16'h0000, 16'h000E, 3'b100);
        add(2'b00, 1'b0, 1'b0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0010, 3'b100);
        add(2'b11, 1'b0, 1'b0, 3'b000, 9'h1FE, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0012, 3'b100);
        add(2'b10, 1'b0, 1'b0, 3'b111, 9'h000, 16'h1235, 3'b000, 3'b000, 1'b0, 1'b1, 16'h0000, 16'h1234, 3'b100);
        add(2'b10, 1'b0, 1'b0, 3'b111, 9'h000, 16'h0041, 3'b000, 3'b000, 1'b0, 1'b1, 16'h0000, 16'h0040, 3'b100);
        add(2'b00, 1'b0, 1'b1, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0042, 16'h0042, 3'b100);
        add(2'b00, 1'b0, 1'b0, 3'b000, 9'h000, 16'h0000, 3'b111, 3'b011, 1'b0, 1'b0, 16'h0000, 16'h0044, 3'b011);
        add(2'b11, 1'b0, 1'b0, 3'b001, 9'h010, 16'h0000, 3'b100, 3'b011, 1'b0, 1'b0, 16'h0000, 16'h0046, 3'b011);
        add(2'b00, 1'b0, 1'b0, 3'b000, 9'h000, 16'h0000, 3'b111, 3'b110, 1'b0, 1'b0, 16'h0000, 16'h0048, 3'b110);
        add(2'b11, 1'b0, 1'b0, 3'b001, 9'h004, 16'h0000, 3'b100, 3'b011, 1'b0, 1'b1, 16'h0000, 16'h0052, 3'b010);
        add(2'b11, 1'b0, 1'b0, 3'b001, 9'h004, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0054, 3'b010);
        add(2'b11, 1'b0, 1'b0, 3'b110, 9'h002, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b1, 16'h0000, 16'h005A, 3'b010);
        add(2'b11, 1'b0, 1'b0, 3'b011, 9'h002, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h005C, 3'b010);
        add(2'b11, 1'b0, 1'b0, 3'b010, 9'h100, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b1, 16'h0000, 16'hFE5E, 3'b010);
        add(2'b01, 1'b0, 1'b0, 3'b111, 9'h010, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 16'hFE60, 3'b010);
        add(2'b10, 1'b0, 1'b0, 3'b100, 9'h000, 16'hFFFF, 3'b000, 3'b000, 1'b0, 1'b1, 16'h0000, 16'hFFFE, 3'b010);
        add(2'b00, 1'b0, 1'b0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'b010);
        add(2'b11, 1'b0, 1'b0, 3'b111, 9'h004, 16'h0000, 3'b111, 3'b111, 1'b1, 1'b1, 16'h0000, 16'h0000, 3'b010);
        add(2'b11, 1'b0, 1'b0, 3'b101, 9'h004, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0002, 3'b010);

        // Reset state
        repeat (2) step();
        check("reset_pc", 32'(bus.pc), 32'h0000);
        check("reset_flags", 32'(bus.flags), 32'h0);
        check("reset_halted", 32'(bus.halted), 32'h0);
        rst_n = 1'b1;

        // Chained directed vectors
        foreach (vecs[i]) begin
            drive(vecs[i].branch, vecs[i].halt_in, vecs[i].pcs, vecs[i].ccc, vecs[i].imm,
                  vecs[i].br_reg, vecs[i].flag_we, vecs[i].alu_flags, vecs[i].stall);
            #1;
            check($sformatf("v%0d_taken", i), 32'(bus.taken), 32'(vecs[i].exp_taken));
            check($sformatf("v%0d_wb_pcs", i), 32'(bus.wb_pcs), 32'(vecs[i].exp_wb));
            step();
            check($sformatf("v%0d_pc", i), 32'(bus.pc), 32'(vecs[i].exp_pc));
            check($sformatf("v%0d_flags", i), 32'(bus.flags), 32'(vecs[i].exp_flags));
            check($sformatf("v%0d_halted", i), 32'(bus.halted), 32'h0);
        end

        // Halt with a simultaneous taken-able branch: halt wins, pc stays on the HLT address
        drive(2'b10, 1'b0, 1'b0, 3'b111, 9'h000, 16'h0020, 3'b000, 3'b000, 1'b0);
        step();
        check("goto_20", 32'(bus.pc), 32'h0020);
        drive(2'b11, 1'b1, 1'b0, 3'b111, 9'h010, 16'h0000, 3'b111, 3'b101, 1'b0);
        #1;
        check("halt_taken_suppressed", 32'(bus.taken), 32'h0);
        step();
        check("halt_pc", 32'(bus.pc), 32'h0020);
        check("halt_flags", 32'(bus.flags), 32'h2);
        check("halt_halted", 32'(bus.halted), 32'h1);

        // Frozen while halted regardless of inputs
        for (int k = 0; k < 50; k++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 3'($urandom_range(0, 7)),
                  9'($urandom_range(0, 511)), 16'($urandom_range(0, 65535)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            #1;
            check("halted_taken", 32'(bus.taken), 32'h0);
            step();
            check("halted_pc", 32'(bus.pc), 32'h0020);
            check("halted_flags", 32'(bus.flags), 32'h2);
            check("halted_state", 32'(bus.halted), 32'h1);
        end

        // Asynchronous reset mid-halt, observed before any clock edge
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", 32'(bus.pc), 32'h0000);
        check("async_rst_halted", 32'(bus.halted), 32'h0);
        check("async_rst_flags", 32'(bus.flags), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_pc", 32'(bus.pc), 32'h0002);

        // Stall holds off a pending halt; halt lands on the first unstalled cycle
        drive(2'b00, 1'b0, 1'b0, 3'b000, 9'h000, 16'h0000, 3'b111, 3'b100, 1'b0);
        step();
        check("pre_stall_pc", 32'(bus.pc), 32'h0004);
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 1'b1, 1'b0, 3'b111, 9'h010, 16'h0000, 3'b111, 3'b011, 1'b1);
            step();
            check("stall_pc", 32'(bus.pc), 32'h0004);
            check("stall_flags", 32'(bus.flags), 32'h4);
            check("stall_halted", 32'(bus.halted), 32'h0);
        end
        drive(2'b11, 1'b1, 1'b0, 3'b111, 9'h010, 16'h0000, 3'b111, 3'b011, 1'b0);
        step();
        check("unstall_halted", 32'(bus.halted), 32'h1);
        check("unstall_pc", 32'(bus.pc), 32'h0004);
        check("unstall_flags", 32'(bus.flags), 32'h4);

        // Reset, then wrap from 0xFFFE
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(2'b10, 1'b0, 1'b0, 3'b111, 9'h000, 16'hFFFE, 3'b000, 3'b000, 1'b0);
        step();
        check("wrap_setup", 32'(bus.pc), 32'hFFFE);
        idle();
        #1;
        check("wrap_plus2", 32'(bus.pc_plus2), 32'h0000);
        step();
        check("wrap_pc", 32'(bus.pc), 32'h0000);
        check("wrap_halted", 32'(bus.halted), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
